// File: rtl/cpu_pkg.sv
// Shared definitions for the board CPU front end: fetch states, next-PC
// select codes, the halting instruction word and the next-PC arithmetic.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  // All sums wrap modulo 2^32; jalr clears bit 0 as RISC-V requires.
  function automatic logic [31:0] calc_npc(
    input logic [1:0]  sel,
    input logic [31:0] pc,
    input logic        br_taken,
    input logic [31:0] imm,
    input logic [31:0] rs1_data
  );
    logic [31:0] result;
    result = pc + 32'd4;
    case (sel)
      NPC_PLUS4:  result = pc + 32'd4;
      NPC_BRANCH: result = br_taken ? (pc + imm) : (pc + 32'd4);
      NPC_JAL:    result = pc + imm;
      NPC_JALR:   result = (rs1_data + imm) & ~32'h1;
      default:    result = pc + 32'd4;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a
// rising-edge detector producing a one-clk pulse.
module sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], d};
    end
  end

  // sync_reg[2] is the previous synchronised value.
  assign rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: program counter, next-PC selection, and the
// run/step/halt controller that decides when an instruction retires.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EBREAK   = EBREAK_INSTR
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cpu_en,
  input  logic               run_mode,
  input  logic               step_req,
  input  logic               halt_clr,
  input  logic [31:0]        instr,
  input  logic [1:0]         npc_sel,
  input  logic               br_taken,
  input  logic [31:0]        imm,
  input  logic [31:0]        rs1_data,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               commit,
  output logic [1:0]         state,
  output logic               misalign_err,
  output logic [31:0]        retired
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  retired_reg, retired_next;
  logic         err_reg, err_next;
  logic         pend_reg, pend_next;
  logic         step_rise;
  logic         adv;
  logic         halt_ebreak;
  logic         halt_misalign;
  logic [31:0]  npc;

  sync_edge u_step_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (step_req),
    .rise (step_rise)
  );

  assign npc           = calc_npc(npc_sel, pc_reg, br_taken, imm, rs1_data);
  assign adv           = cpu_en & ((state_reg == ST_RUN) | (state_reg == ST_STEP));
  assign halt_ebreak   = (instr == EBREAK);
  assign halt_misalign = (npc[1:0] != 2'b00);
  // Combinational so RF/DM write enables act in the same cycle as the fetch.
  assign commit        = adv & ~halt_ebreak & ~halt_misalign;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    err_next     = err_reg;
    pend_next    = pend_reg;

    case (state_reg)
      ST_IDLE: begin
        if (run_mode) begin
          state_next = ST_RUN;
        end else if (pend_reg) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        if (adv && (halt_ebreak || halt_misalign)) begin
          state_next = ST_HALT;
        end else if (!run_mode) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (adv) begin
          state_next = (halt_ebreak || halt_misalign) ? ST_HALT : ST_IDLE;
        end
      end
      ST_HALT: begin
        if (halt_clr) begin
          state_next = ST_IDLE;
          pc_next    = RESET_PC;
          err_next   = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (commit) begin
      pc_next      = npc;
      retired_next = retired_reg + 32'd1;
    end
    if (adv && !halt_ebreak && halt_misalign) begin
      err_next = 1'b1;
    end

    // The pending step is claimed on STEP entry, so an edge seen while the
    // step is still waiting for cpu_en queues the following step.
    if (state_reg == ST_IDLE && state_next == ST_STEP) begin
      pend_next = 1'b0;
    end
    if (step_rise) begin
      pend_next = 1'b1;
    end
    if (state_next == ST_RUN || state_next == ST_HALT || state_reg == ST_HALT) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      retired_reg <= 32'd0;
      err_reg     <= 1'b0;
      pend_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      err_reg     <= err_next;
      pend_reg    <= pend_next;
    end
  end

  assign pc           = pc_reg;
  assign pc_plus4     = pc_reg + 32'd4;
  assign imem_addr    = pc_reg[IMEM_AW+1:2];
  assign state        = state_reg;
  assign misalign_err = err_reg;
  assign retired      = retired_reg;

endmodule
